divider_control: RTL and testbench

Sequencing FSM for the unsigned shift-subtract (restoring) divider. It has no data inputs: it steps the divider datapath through load, initial shift, WIDTH subtract/shift iterations and a final correction shift, then raises `rdy`. Each cycle it drives register write enables, shift controls and the 6-bit ALU function code. The datapath alone uses the remainder sign to choose restore vs. keep and the quotient bit.

---
 rtl/divider_control.sv | 123 ++++++++++++
 tb/tb_divider_control.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/divider_control.sv
// Sequencer for the unsigned restoring shift-subtract divider: load, SHIFT0, WIDTH SUB/SHIFT pairs, FIX, DONE.
// Optional feature: define DIV_CTRL_ABORT_EN to let run=0 abort an operation between LOAD and FIX.
module divider_control #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       rdy,
  output logic       SLL_ctrl,
  output logic       SRL_ctrl,
  output logic       w_ctrl_reg1,
  output logic       w_ctrl_reg2,
  output logic [5:0] funct
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [5:0] FUNCT_NONE = 6'b000000;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT0, SUB, SHIFT, FIX, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_iter_c;
  logic            abort_c;

  logic            rdy_q, rdy_d;
  logic            sll_q, sll_d;
  logic            srl_q, srl_d;
  logic            w1_q, w1_d;
  logic            w2_q, w2_d;
  logic [5:0]      funct_q, funct_d;

  assign last_iter_c = (32'(cnt_q) + 32'd1) >= WIDTH;

`ifdef DIV_CTRL_ABORT_EN
  assign abort_c = !run && (state_q inside {LOAD, SHIFT0, SUB, SHIFT, FIX});
`else
  assign abort_c = 1'b0;
`endif

  // Next state and iteration counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:   if (run) state_d = LOAD;
      LOAD: begin
        cnt_d   = '0;
        state_d = SHIFT0;
      end
      SHIFT0: state_d = SUB;
      SUB:    state_d = SHIFT;
      SHIFT: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = last_iter_c ? FIX : SUB;
      end
      FIX:    state_d = DONE;
      DONE:   if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_c) state_d = IDLE;
  end

  // Moore output decode of the current state; registered below
  always_comb begin
    rdy_d   = 1'b0;
    sll_d   = 1'b0;
    srl_d   = 1'b0;
    w1_d    = 1'b0;
    w2_d    = 1'b0;
    funct_d = FUNCT_NONE;
    unique case (state_q)
      LOAD:   w1_d = 1'b1;
      SHIFT0: sll_d = 1'b1;
      SUB: begin
        funct_d = FUNCT_SUBU;
        w2_d    = 1'b1;
      end
      SHIFT: begin
        sll_d   = 1'b1;
        funct_d = FUNCT_ADDU;
      end
      FIX:    srl_d = 1'b1;
      DONE:   rdy_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      sll_q   <= 1'b0;
      srl_q   <= 1'b0;
      w1_q    <= 1'b0;
      w2_q    <= 1'b0;
      funct_q <= FUNCT_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      sll_q   <= sll_d;
      srl_q   <= srl_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      funct_q <= funct_d;
    end
  end

  assign rdy         = rdy_q;
  assign SLL_ctrl    = sll_q;
  assign SRL_ctrl    = srl_q;
  assign w_ctrl_reg1 = w1_q;
  assign w_ctrl_reg2 = w2_q;
  assign funct       = funct_q;

endmodule

// File: tb/tb_divider_control.sv
// Randomized bench for divider_control against an offset-based reference model of one operation.
module tb_divider_control;

  localparam int W   = 32;
  localparam int LAT = 2 * W + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       rdy, SLL_ctrl, SRL_ctrl, w_ctrl_reg1, w_ctrl_reg2;
  logic [5:0] funct;

  divider_control #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .run(run), .rdy(rdy), .SLL_ctrl(SLL_ctrl), .SRL_ctrl(SRL_ctrl),
    .w_ctrl_reg1(w_ctrl_reg1), .w_ctrl_reg2(w_ctrl_reg2), .funct(funct)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: m = -1 idle, otherwise cycles since LOAD became the state.
  // Output vector {rdy, sll, srl, w1, w2, funct[5:0]}
  function automatic logic [10:0] ref_out(input int m);
    if (m < 0)            return 11'b0;
    if (m == 0)           return {5'b00010, 6'b000000};
    if (m == 1)           return {5'b01000, 6'b000000};
    if (m <= 2 * W + 1)   return ((m - 2) % 2 == 0) ? {5'b00001, 6'b100011} : {5'b01000, 6'b100001};
    if (m == 2 * W + 2)   return {5'b00100, 6'b000000};
    return {5'b10000, 6'b000000};
  endfunction

  function automatic int ref_next(input int m, input logic r);
    if (m < 0) return r ? 0 : -1;
    if (m <= 2 * W + 2) begin
`ifdef DIV_CTRL_ABORT_EN
      if (!r) return -1;
`endif
      return m + 1;
    end
    return r ? m : -1;
  endfunction

  int          m_q   = -1;
  int          cyc   = 0;
  int          e_cyc = 0;
  int          lat   = 0;
  bit          rdy_seen;
  logic [10:0] exp_out = '0;
  int          c_sll, c_srl, c_w1, c_sub;

  task automatic tick();
    logic [10:0] act;
    int nx;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      m_q     = -1;
      exp_out = '0;
    end else begin
      exp_out = ref_out(m_q);
      nx = ref_next(m_q, run);
      if (m_q < 0 && nx == 0) e_cyc = cyc;
      m_q = nx;
    end
    @(negedge clk);
    act = {rdy, SLL_ctrl, SRL_ctrl, w_ctrl_reg1, w_ctrl_reg2, funct};
    check_eq("outs", 32'(act), 32'(exp_out));
    check_eq("mutex", {30'd0, SLL_ctrl & SRL_ctrl, w_ctrl_reg1 & w_ctrl_reg2}, 32'd0);
    c_sll += int'(SLL_ctrl);
    c_srl += int'(SRL_ctrl);
    c_w1  += int'(w_ctrl_reg1);
    c_sub += int'(w_ctrl_reg2 && funct == 6'b100011);
    if (rdy && !rdy_seen) begin
      rdy_seen = 1'b1;
      lat      = cyc - e_cyc;
    end
  endtask

  task automatic run_op(input int hold);
    c_sll = 0; c_srl = 0; c_w1 = 0; c_sub = 0; rdy_seen = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 200 && !rdy_seen; i++) begin
      tick();
`ifdef DIV_CTRL_ABORT_EN
      run = 1'b1;
`else
      run = (m_q >= 0 && m_q <= 2 * W + 1) ? 1'($urandom_range(0, 1)) : 1'b1;
`endif
    end
    check_eq("rdy_timeout", 32'(rdy_seen), 32'd1);
    check_eq("latency", 32'(lat), 32'(LAT));
    run = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    check_eq("rdy_held", 32'(rdy), 32'd1);
    check_eq("cnt_w1", 32'(c_w1), 32'd1);
    check_eq("cnt_sll", 32'(c_sll), 32'(W + 1));
    check_eq("cnt_sub", 32'(c_sub), 32'(W));
    check_eq("cnt_srl", 32'(c_srl), 32'd1);
    run = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    run = 1'($urandom_range(0, 1));
    rdy_seen = 1'b0;
    #1;
    check_eq("rst_async", {21'd0, rdy, SLL_ctrl, SRL_ctrl, w_ctrl_reg1, w_ctrl_reg2, funct}, 32'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    tick();

    run_op(2000);
    for (int op = 0; op < 4; op++) begin
      int gap;
      gap = $urandom_range(0, 5);
      run = 1'b0;
      for (int i = 0; i < gap; i++) tick();
      run_op($urandom_range(1, 20));
    end

    // Reset mid-SUB: outputs must clear before the next clock edge
    run = 1'b1;
    for (int i = 0; i < 100 && m_q != 10; i++) tick();
    check_eq("reach_sub", 32'(m_q), 32'd10);
    rst = 1'b0;
    #1;
    check_eq("rst_mid", {21'd0, rdy, SLL_ctrl, SRL_ctrl, w_ctrl_reg1, w_ctrl_reg2, funct}, 32'd0);
    m_q = -1;
    run = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    run_op(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
